reg_writeback: RTL and testbench

Writeback arbiter and late-result buffer feeding the register file's single write port and its $k0 (register 26) PC-backup port. Merges the in-order WB-stage write, results from multi-cycle units (valid/ready) and the interrupt PC backup into one write per cycle. Keeps a per-register pending scoreboard so the hazard unit can stall readers of registers whose late result has not landed.

---
 rtl/reg_writeback_pkg.sv | 18 +
 rtl/reg_writeback_fifo.sv | 55 +++++
 rtl/reg_writeback.sv | 111 +++++++++++
 tb/tb_reg_writeback.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared register-file constants and the writeback entry type.
// Used by the writeback block, the register file and the hazard unit.
package reg_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] K0_ADDR   = 5'd26;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = 5'd0;

  // One buffered late result: destination register and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: synchronous FIFO of DEPTH {addr,data} entries for late results.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   push, push_entry write an entry at the tail (caller guarantees not full)
//   pop              drop the head entry (caller guarantees not empty)
//   head             current head entry (no bypass of a same-cycle push)
//   count            occupancy, 0..DEPTH
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately not reset; count and the
  // pointers define which entries are valid, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges the WB-stage write, buffered multi-cycle results and
// the interrupt PC backup into the register file's write port and $k0 port,
// and tracks which registers still await a late result.
// Ports:
//   pipe_wr_*             in-order WB-stage write (zero latency)
//   late_issue(_addr)     multi-cycle op issued; marks its register pending
//   late_valid/ready/addr/data  late result handshake into the FIFO
//   irq_backup, irq_pc    PC backup into register 26, never blocked
//   rf_wr_*               register-file write port
//   rf_pc_backup, rf_reg26  register-file PC-backup port
//   pending               per-register outstanding late result (bit 0 = 0)
//   fifo_count            late-result FIFO occupancy
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_wr_en,
  input  logic [REG_ADDR_W-1:0]  pipe_wr_addr,
  input  logic [DATA_W-1:0]      pipe_wr_data,
  input  logic                   late_issue,
  input  logic [REG_ADDR_W-1:0]  late_issue_addr,
  input  logic                   late_valid,
  output logic                   late_ready,
  input  logic [REG_ADDR_W-1:0]  late_addr,
  input  logic [DATA_W-1:0]      late_data,
  input  logic                   irq_backup,
  input  logic [DATA_W-1:0]      irq_pc,
  output logic                   rf_wr_en,
  output logic [REG_ADDR_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data,
  output logic                   rf_pc_backup,
  output logic [DATA_W-1:0]      rf_reg26,
  output logic [NUM_REGS-1:0]    pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int COUNT_W = $clog2(DEPTH) + 1;

  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic                fifo_empty;
  logic                live_pipe;
  logic                pipe_dropped;
  logic                head_blocked;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] pending_next;

  assign fifo_empty   = (fifo_count == '0);
  assign live_pipe    = pipe_wr_en && (pipe_wr_addr != ZERO_ADDR);
  // The backup port owns register 26 this cycle; a pipe write to it is lost.
  assign pipe_dropped = irq_backup && (pipe_wr_addr == K0_ADDR);
  assign head_blocked = irq_backup && (head.addr == K0_ADDR);

  // Ready ignores a same-cycle pop, so a full FIFO never pushes and pops at once.
  assign late_ready = (fifo_count < COUNT_W'(DEPTH));
  // Results for register 0 are acknowledged but never buffered.
  assign push       = late_valid && late_ready && (late_addr != ZERO_ADDR);
  // A dropped pipe write still counts as live: the head waits for a free port.
  assign pop        = !fifo_empty && !live_pipe && !head_blocked;

  assign push_entry = '{addr: late_addr, data: late_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = head.addr;
    rf_wr_data = head.data;
    if (live_pipe) begin
      rf_wr_en   = !pipe_dropped;
      rf_wr_addr = pipe_wr_addr;
      rf_wr_data = pipe_wr_data;
    end else if (pop) begin
      rf_wr_en = 1'b1;
    end
    // Outputs stay quiet for the whole reset window, not just after the edge.
    if (reset) rf_wr_en = 1'b0;
  end

  assign rf_pc_backup = irq_backup && !reset;
  assign rf_reg26     = irq_pc;

  // Clear first, then set: a new issue to the register being drained wins.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head.addr] = 1'b0;
    if (late_issue && (late_issue_addr != ZERO_ADDR))
      pending_next[late_issue_addr] = 1'b1;
    pending_next[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        late_issue;
  logic [4:0]  late_issue_addr;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic        irq_backup;
  logic [31:0] irq_pc;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_pc_backup;
  logic [31:0] rf_reg26;
  logic [31:0] pending;
  logic [1:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .pipe_wr_en      (pipe_wr_en),
    .pipe_wr_addr    (pipe_wr_addr),
    .pipe_wr_data    (pipe_wr_data),
    .late_issue      (late_issue),
    .late_issue_addr (late_issue_addr),
    .late_valid      (late_valid),
    .late_ready      (late_ready),
    .late_addr       (late_addr),
    .late_data       (late_data),
    .irq_backup      (irq_backup),
    .irq_pc          (irq_pc),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .rf_wr_data      (rf_wr_data),
    .rf_pc_backup    (rf_pc_backup),
    .rf_reg26        (rf_reg26),
    .pending         (pending),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  wb_entry_t   mdl_q[$];
  logic [31:0] mdl_pend;

  function automatic bit mdl_live();
    return pipe_wr_en && (pipe_wr_addr != 5'd0);
  endfunction

  function automatic bit mdl_drain();
    if (mdl_q.size() == 0) return 1'b0;
    if (mdl_live()) return 1'b0;
    if (irq_backup && mdl_q[0].addr == 5'd26) return 1'b0;
    return 1'b1;
  endfunction

  // State update on each clock edge or asynchronous reset.
  initial begin
    mdl_pend = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mdl_q.delete();
        mdl_pend = '0;
      end else begin
        bit        drain;
        bit        accept;
        wb_entry_t e;
        drain  = mdl_drain();
        accept = late_valid && (mdl_q.size() < DEPTH);
        if (drain) begin
          mdl_pend[mdl_q[0].addr] = 1'b0;
          void'(mdl_q.pop_front());
        end
        if (accept && late_addr != 5'd0) begin
          e.addr = late_addr;
          e.data = late_data;
          mdl_q.push_back(e);
        end
        if (late_issue && late_issue_addr != 5'd0) mdl_pend[late_issue_addr] = 1'b1;
      end
    end
  end

  // Per-cycle comparison, mid-cycle while inputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("rst_pc_backup", {31'd0, rf_pc_backup}, 32'd0);
        check("rst_count", {30'd0, fifo_count}, 32'd0);
        check("rst_pending", pending, 32'd0);
      end else begin
        bit          exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        exp_en = 1'b0; exp_addr = '0; exp_data = '0;
        if (mdl_live()) begin
          exp_en   = !(irq_backup && pipe_wr_addr == 5'd26);
          exp_addr = pipe_wr_addr;
          exp_data = pipe_wr_data;
        end else if (mdl_drain()) begin
          exp_en   = 1'b1;
          exp_addr = mdl_q[0].addr;
          exp_data = mdl_q[0].data;
        end
        check("cyc_rf_wr_en", {31'd0, rf_wr_en}, {31'd0, exp_en});
        if (exp_en) begin
          check("cyc_rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, exp_addr});
          check("cyc_rf_wr_data", rf_wr_data, exp_data);
        end
        check("cyc_pc_backup", {31'd0, rf_pc_backup}, {31'd0, irq_backup});
        if (irq_backup) check("cyc_reg26", rf_reg26, irq_pc);
        check("cyc_late_ready", {31'd0, late_ready}, {31'd0, mdl_q.size() < DEPTH});
        check("cyc_count", {30'd0, fifo_count}, 32'(mdl_q.size()));
        check("cyc_pending", pending, mdl_pend);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wr_en = 0; pipe_wr_addr = '0; pipe_wr_data = '0;
    late_issue = 0; late_issue_addr = '0;
    late_valid = 0; late_addr = '0; late_data = '0;
    irq_backup = 0; irq_pc = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    irq_backup = 1'b1; irq_pc = 32'hFFFF_0000;
    #2;
    check("reset_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("reset_pc_backup_gated", {31'd0, rf_pc_backup}, 32'd0);
    step(); step();
    reset = 1'b0;
    irq_backup = 1'b0;
    #1;
    check("idle_late_ready", {31'd0, late_ready}, 32'd1);
    check("idle_pending", pending, 32'd0);
    check("idle_count", {30'd0, fifo_count}, 32'd0);
    check("idle_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    step();

    // Single late result for register 8.
    late_issue = 1; late_issue_addr = 5'd8;
    step();
    late_issue = 0;
    #1 check("r8_pending_set", pending, 32'h0000_0100);
    step();
    late_valid = 1; late_addr = 5'd8; late_data = 32'h1234;
    step();
    late_valid = 0;
    #1;
    check("r8_wr_en", {31'd0, rf_wr_en}, 32'd1);
    check("r8_wr_addr", {27'd0, rf_wr_addr}, 32'd8);
    check("r8_wr_data", rf_wr_data, 32'h1234);
    check("r8_pending_held", pending, 32'h0000_0100);
    step();
    #1;
    check("r8_pending_clear", pending, 32'd0);
    check("r8_wr_en_after", {31'd0, rf_wr_en}, 32'd0);

    // Pipe writes hold off two late results until it idles.
    pipe_wr_en = 1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'h55;
    late_valid = 1; late_addr = 5'd9; late_data = 32'h99;
    step();
    late_addr = 5'd10; late_data = 32'h1010;
    #1 check("pipe5_addr", {27'd0, rf_wr_addr}, 32'd5);
    step();
    late_valid = 0;
    #1;
    check("full_late_ready", {31'd0, late_ready}, 32'd0);
    check("full_count", {30'd0, fifo_count}, 32'd2);
    step();
    pipe_wr_en = 0;
    #1;
    check("drain9_addr", {27'd0, rf_wr_addr}, 32'd9);
    check("drain9_data", rf_wr_data, 32'h99);
    step();
    #1 check("drain10_addr", {27'd0, rf_wr_addr}, 32'd10);
    step();
    #1 check("drained_ready", {31'd0, late_ready}, 32'd1);

    // PC backup against a pipe write and a queued result for register 26.
    late_valid = 1; late_addr = 5'd26; late_data = 32'h2626;
    step();
    late_valid = 0;
    irq_backup = 1; irq_pc = 32'h0040_0020;
    pipe_wr_en = 1; pipe_wr_addr = 5'd26; pipe_wr_data = 32'hDEAD;
    #1;
    check("irq_pc_backup", {31'd0, rf_pc_backup}, 32'd1);
    check("irq_reg26", rf_reg26, 32'h0040_0020);
    check("irq_pipe_dropped", {31'd0, rf_wr_en}, 32'd0);
    step();
    pipe_wr_en = 0;
    #1;
    check("irq_head_held", {31'd0, rf_wr_en}, 32'd0);
    check("irq_head_count", {30'd0, fifo_count}, 32'd1);
    step();
    irq_backup = 0;
    #1;
    check("k0_drain_addr", {27'd0, rf_wr_addr}, 32'd26);
    check("k0_drain_data", rf_wr_data, 32'h2626);
    step();

    // Re-issue to register 12 while its previous result drains: set wins.
    late_issue = 1; late_issue_addr = 5'd12;
    step();
    late_issue = 0;
    late_valid = 1; late_addr = 5'd12; late_data = 32'hC;
    step();
    late_valid = 0;
    late_issue = 1; late_issue_addr = 5'd12;
    #1 check("r12_pop_addr", {27'd0, rf_wr_addr}, 32'd12);
    step();
    late_issue = 0;
    #1 check("r12_set_wins", pending, 32'h0000_1000);
    late_valid = 1; late_addr = 5'd0; late_data = 32'h77;
    #1 check("r0_ready", {31'd0, late_ready}, 32'd1);
    step();
    late_valid = 0;
    #1;
    check("r0_count", {30'd0, fifo_count}, 32'd0);
    check("r0_no_write", {31'd0, rf_wr_en}, 32'd0);
    check("r0_pending", pending, 32'h0000_1000);
    late_valid = 1; late_addr = 5'd12; late_data = 32'hCC;
    step();
    late_valid = 0;
    step();
    #1 check("r12_cleared", pending, 32'd0);

    // Reset with two buffered results and a pending bit.
    pipe_wr_en = 1; pipe_wr_addr = 5'd7; pipe_wr_data = 32'h77;
    late_issue = 1; late_issue_addr = 5'd3;
    late_valid = 1; late_addr = 5'd4; late_data = 32'h44;
    step();
    late_issue = 0;
    late_addr = 5'd6; late_data = 32'h66;
    step();
    late_valid = 0;
    #1;
    check("pre_rst_count", {30'd0, fifo_count}, 32'd2);
    check("pre_rst_pending", pending, 32'h0000_0008);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_count", {30'd0, fifo_count}, 32'd0);
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("mid_rst_ready", {31'd0, late_ready}, 32'd1);
    step();
    reset = 1'b0;
    pipe_wr_en = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("post_rst_no_write", {31'd0, rf_wr_en}, 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
